// File: rtl/bpsk_frame_loader_if.sv
// Host-side write stream into the BPSK frame loader.
// The host drives data, valid and abort; the loader returns ready.
interface bpsk_frame_loader_if;
  logic [31:0] WrData;
  logic        WrValid;
  logic        WrReady;
  logic        WrAbort;

  modport master (output WrData, output WrValid, output WrAbort, input WrReady);
  modport slave  (input WrData, input WrValid, input WrAbort, output WrReady);
endinterface

// File: rtl/bpsk_frame_loader.sv
// Ping-pong 16-word frame buffer feeding the BPSK modulator.
// Fills one bank from the host while the other is held on Data and handshaken via Int/Done.
module bpsk_frame_loader #(
  parameter int unsigned IntLowCycles  = 4,
  parameter int unsigned DoneBlank     = 32,
  parameter int unsigned TimeoutCycles = 1048576
) (
  input  logic                Clk,
  input  logic                Reset_n,
  bpsk_frame_loader_if.slave  hostWr,
  output logic [31:0]         Data [0:15],
  output logic                Int,
  input  logic                Done,
  output logic                TxDonePulse,
  output logic                TxErr,
  output logic [1:0]          Pending
);

  localparam int unsigned WordW = 32;
  localparam int unsigned Depth = 16;
  localparam int unsigned PtrW  = 4;
  localparam int unsigned CntW  = 21;

  typedef enum logic [1:0] {TxIdle, TxAssert, TxRelease} txState_t;

  logic [WordW-1:0] bank [0:1][0:Depth-1];
  logic [1:0]       full;
  logic [1:0]       fullNext;
  logic             fillBank;
  logic             txBank;
  logic             txBankNext;
  logic [PtrW-1:0]  wrPtr;
  logic             wrXfer;
  logic             fillDone;
  logic             releaseBank;
  logic             doneMeta;
  logic             doneS;

  txState_t         state;
  txState_t         stateNext;
  logic [CntW-1:0]  cnt;
  logic [CntW-1:0]  cntNext;
  logic             intNext;
  logic             pulseNext;
  logic             errNext;

  // Fill side: abort wins over a same-cycle transfer, dropping that word.
  assign hostWr.WrReady = !full[fillBank];
  assign wrXfer   = hostWr.WrValid && hostWr.WrReady && !hostWr.WrAbort;
  assign fillDone = wrXfer && (wrPtr == PtrW'(Depth - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wrPtr    <= '0;
      fillBank <= 1'b0;
    end else if (hostWr.WrAbort) begin
      wrPtr    <= '0;
    end else if (wrXfer) begin
      wrPtr <= wrPtr + PtrW'(1);
      if (fillDone) fillBank <= ~fillBank;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < Depth; i++)
          bank[b][i] <= '0;
    end else if (wrXfer) begin
      bank[fillBank][wrPtr] <= hostWr.WrData;
    end
  end

  // The two banks' full flags can set and clear in the same cycle without conflict.
  always_comb begin
    fullNext = full;
    if (releaseBank) fullNext[txBank]   = 1'b0;
    if (fillDone)    fullNext[fillBank] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) full <= 2'b00;
    else          full <= fullNext;
  end

  // Done arrives from the modulator's generated clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      doneMeta <= 1'b0;
      doneS    <= 1'b0;
    end else begin
      doneMeta <= Done;
      doneS    <= doneMeta;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= TxIdle;
      cnt         <= '0;
      Int         <= 1'b0;
      TxDonePulse <= 1'b0;
      TxErr       <= 1'b0;
      txBank      <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      Int         <= intNext;
      TxDonePulse <= pulseNext;
      TxErr       <= errNext;
      txBank      <= txBankNext;
    end
  end

  // TX handshake: Done only counts once the blanking window after Int rise has passed.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    intNext     = Int;
    pulseNext   = 1'b0;
    errNext     = TxErr;
    txBankNext  = txBank;
    releaseBank = 1'b0;
    unique case (state)
      TxIdle: begin
        if (full[txBank]) begin
          stateNext = TxAssert;
          intNext   = 1'b1;
          cntNext   = '0;
        end
      end
      TxAssert: begin
        cntNext = cnt + CntW'(1);
        if ((cnt >= CntW'(DoneBlank)) && doneS) begin
          stateNext = TxRelease;
          intNext   = 1'b0;
          pulseNext = 1'b1;
          cntNext   = '0;
        end else if (cnt == CntW'(TimeoutCycles - 1)) begin
          stateNext = TxRelease;
          intNext   = 1'b0;
          errNext   = 1'b1;
          cntNext   = '0;
        end
      end
      TxRelease: begin
        cntNext = cnt + CntW'(1);
        if (cnt == CntW'(IntLowCycles - 1)) begin
          releaseBank = 1'b1;
          txBankNext  = ~txBank;
          stateNext   = TxIdle;
          cntNext     = '0;
        end
      end
      default: begin
        stateNext = TxIdle;
        intNext   = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) Data[i] = bank[txBank][i];
  end

  assign Pending = 2'(full[0]) + 2'(full[1]);

endmodule
